// File: rtl/tetris_vga_pkg.sv
// Shared types and constants for the start-screen pixel generator.
package tetris_vga_pkg;

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned RGB_W        = 12;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam logic [RGB_W-1:0] BLACK_RGB  = 12'h000;
  localparam logic [RGB_W-1:0] BG_RGB     = 12'h111;
  localparam logic [RGB_W-1:0] BANNER_RGB = 12'hFFF;

  // Index 0 is the rightmost entry: 00:F00, 01:0F0, 10:00F, 11:FF0
  localparam logic [3:0][RGB_W-1:0] TITLE_PAL = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};

  typedef enum logic [1:0] {
    ST_WAIT_RELEASE,
    ST_WAIT_PRESS,
    ST_FADE,
    ST_DONE
  } start_state_t;

  typedef struct packed {
    logic active;
    logic in_title;
    logic in_banner;
  } pix_flags_t;

  function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] rgb, input logic [1:0] lvl);
    return {rgb[11:8] >> lvl, rgb[7:4] >> lvl, rgb[3:0] >> lvl};
  endfunction

endpackage

// File: rtl/start_scene_pixel_if.sv
// Pixel/key bus between the video timing side and the start-screen generator.
interface start_scene_pixel_if;
  import tetris_vga_pkg::*;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [1:0]       scene_state;
  logic             start_key;
  logic [RGB_W-1:0] vga_rgb;
  logic             game_start;
  logic             start_done;

  modport master (
    output h_cnt, v_cnt, scene_state, start_key,
    input  vga_rgb, game_start, start_done
  );

  modport slave (
    input  h_cnt, v_cnt, scene_state, start_key,
    output vga_rgb, game_start, start_done
  );
endinterface

// File: rtl/start_key_sync.sv
// Two-flop synchroniser with rising-edge detect for the raw start button.
module start_key_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_key_sync,
  output logic o_key_valid,
  output logic o_key_rise_c
);
  logic r_meta, r_sync, r_prev;
  logic [1:0] r_fill;

  // r_fill marks when r_sync reflects a real post-reset sample of the key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_fill <= 2'b00;
    end else begin
      r_meta <= i_key;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fill <= {r_fill[0], 1'b1};
    end
  end

  assign o_key_sync   = r_sync;
  assign o_key_valid  = r_fill[1];
  assign o_key_rise_c = r_sync & ~r_prev;
endmodule

// File: rtl/start_scene_pixel.sv
// Start-screen renderer (2-stage pixel pipeline) and start-key sequencing FSM.
// Define START_FADE_EN to compile in the title fade-out before game start.
module start_scene_pixel
  import tetris_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned TITLE_X0  = 160,
  parameter int unsigned TITLE_Y0  = 120,
  parameter int unsigned TITLE_W   = 320,
  parameter int unsigned TITLE_H   = 80,
  parameter int unsigned BANNER_X0 = 224,
  parameter int unsigned BANNER_Y0 = 320,
  parameter int unsigned BANNER_W  = 192,
  parameter int unsigned BANNER_H  = 32
) (
  input logic                clk,
  input logic                rst,
  start_scene_pixel_if.slave bus
);
  start_state_t     r_state, w_state_nxt;
  logic             w_key_sync, w_key_valid, w_key_rise;
  logic             w_gs_nxt, r_game_start, r_start_done;
  logic [CNT_W-1:0] r_h, r_v;
  logic [1:0]       r_scene;
  pix_flags_t       w_flags, r_flags;
  logic [RGB_W-1:0] w_rgb, r_rgb;
  logic             w_unused;

  start_key_sync u_key_sync (
    .clk          (clk),
    .rst          (rst),
    .i_key        (bus.start_key),
    .o_key_sync   (w_key_sync),
    .o_key_valid  (w_key_valid),
    .o_key_rise_c (w_key_rise)
  );

  function automatic logic in_rect(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y,
                                   input int unsigned x0, input int unsigned y0,
                                   input int unsigned w, input int unsigned h);
    return (32'(x) >= x0) && (32'(x) < x0 + w) && (32'(y) >= y0) && (32'(y) < y0 + h);
  endfunction

`ifdef START_FADE_EN
  logic [1:0] r_fade_lvl, w_fade_nxt, r_scene_prev;
  logic       w_scene_chg;

  assign w_scene_chg = (bus.scene_state != r_scene_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fade_lvl   <= 2'd0;
      r_scene_prev <= 2'd0;
    end else begin
      r_fade_lvl   <= w_fade_nxt;
      r_scene_prev <= bus.scene_state;
    end
  end
`endif

  // Stage-1 region decode, evaluated on the incoming counters
  always_comb begin
    w_flags.active    = (32'(bus.h_cnt) < H_ACTIVE) && (32'(bus.v_cnt) < V_ACTIVE);
    w_flags.in_title  = in_rect(bus.h_cnt, bus.v_cnt, TITLE_X0, TITLE_Y0, TITLE_W, TITLE_H);
    w_flags.in_banner = in_rect(bus.h_cnt, bus.v_cnt, BANNER_X0, BANNER_Y0, BANNER_W, BANNER_H);
  end

  // Stage-2 colour select; title wins over banner
  always_comb begin
    w_rgb = BLACK_RGB;
    if (r_flags.active && (r_state != ST_DONE)) begin
      if (r_flags.in_title)                     w_rgb = TITLE_PAL[r_scene];
      else if (r_flags.in_banner && r_scene[0]) w_rgb = BANNER_RGB;
      else                                      w_rgb = BG_RGB;
`ifdef START_FADE_EN
      if (r_state == ST_FADE) w_rgb = dim_rgb(w_rgb, r_fade_lvl);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h     <= '0;
      r_v     <= '0;
      r_scene <= 2'd0;
      r_flags <= '0;
      r_rgb   <= BLACK_RGB;
    end else begin
      r_h     <= bus.h_cnt;
      r_v     <= bus.v_cnt;
      r_scene <= bus.scene_state;
      r_flags <= w_flags;
      r_rgb   <= w_rgb;
    end
  end

  // Stage-1 coordinates are kept as debug taps only
  assign w_unused = ^{r_h, r_v};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_WAIT_RELEASE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gs_nxt    = 1'b0;
`ifdef START_FADE_EN
    w_fade_nxt  = r_fade_lvl;
`endif
    case (r_state)
      ST_WAIT_RELEASE: if (w_key_valid && !w_key_sync) w_state_nxt = ST_WAIT_PRESS;
      ST_WAIT_PRESS: begin
        if (w_key_rise) begin
`ifdef START_FADE_EN
          w_state_nxt = ST_FADE;
          w_fade_nxt  = 2'd0;
`else
          w_state_nxt = ST_DONE;
          w_gs_nxt    = 1'b1;
`endif
        end
      end
`ifdef START_FADE_EN
      ST_FADE: begin
        if (w_scene_chg) begin
          if (r_fade_lvl == 2'd3) begin
            w_state_nxt = ST_DONE;
            w_gs_nxt    = 1'b1;
          end else begin
            w_fade_nxt = r_fade_lvl + 2'd1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_game_start <= 1'b0;
      r_start_done <= 1'b0;
    end else begin
      r_game_start <= w_gs_nxt;
      r_start_done <= r_start_done | w_gs_nxt;
    end
  end

  assign bus.vga_rgb    = r_rgb;
  assign bus.game_start = r_game_start;
  assign bus.start_done = r_start_done;
endmodule

// File: tb/tb_start_scene_pixel.sv
// Scoreboard bench for start_scene_pixel: stimulus queues expectations, a negedge monitor checks them.
module tb_start_scene_pixel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  start_scene_pixel_if bus ();

  start_scene_pixel dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        sd;
    int          gs;
    string       name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int gs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count game_start pulses, then check every expectation due this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.game_start === 1'b1) gs_cnt = gs_cnt + 1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        total = total + 1;
        if (e.due < cyc) begin
          bad = bad + 1;
          $display("FAIL %s: check overdue at cycle %0d, wanted cycle %0d", e.name, cyc, e.due);
        end else if (bus.vga_rgb !== e.rgb || bus.start_done !== e.sd || gs_cnt != e.gs) begin
          bad = bad + 1;
          $display("FAIL %s: got rgb=%h start_done=%b pulses=%0d, want rgb=%h start_done=%b pulses=%0d",
                   e.name, bus.vga_rgb, bus.start_done, gs_cnt, e.rgb, e.sd, e.gs);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_px(input int h, input int v, input int s);
    bus.h_cnt       = 10'(h);
    bus.v_cnt       = 10'(v);
    bus.scene_state = 2'(s);
  endtask

  task automatic expect_at(input int lat, input logic [11:0] rgb, input logic sd,
                           input int gs, input string name);
    exp_t e;
    e.due  = cyc + lat;
    e.rgb  = rgb;
    e.sd   = sd;
    e.gs   = gs;
    e.name = name;
    q.push_back(e);
  endtask

  int          bh[12] = '{159, 160, 479, 480, 200, 200, 224, 416, 300, 639, 0, 1023};
  int          bv[12] = '{150, 150, 199, 150, 200, 119, 320, 340, 352, 479, 480, 1023};
  int          bs[12] = '{0, 0, 3, 0, 1, 0, 3, 1, 1, 0, 0, 3};
  logic [11:0] brgb[12] = '{12'h111, 12'hF00, 12'hFF0, 12'h111, 12'h111, 12'h111,
                            12'hFFF, 12'h111, 12'h111, 12'h111, 12'h000, 12'h000};

  initial begin
    set_px(0, 0, 0);
    bus.start_key = 1'b0;

    // Reset state
    @(posedge clk); #2;
    expect_at(0, 12'h000, 1'b0, 0, "reset_state");
    tick(1);

    // Release: one flushed cycle, then title in palette entry 2
    set_px(200, 150, 2);
    rst = 1'b0;
    expect_at(1, 12'h000, 1'b0, 0, "flush_after_release");
    expect_at(2, 12'h00F, 1'b0, 0, "title_pal2");
    tick(3);

    // Banner blink and inactive region
    set_px(300, 330, 1); expect_at(2, 12'hFFF, 1'b0, 0, "banner_on");  tick(2);
    set_px(300, 330, 0); expect_at(2, 12'h111, 1'b0, 0, "banner_off"); tick(2);
    set_px(640, 330, 0); expect_at(2, 12'h000, 1'b0, 0, "h_inactive"); tick(2);

    // Rectangle and active-area boundaries
    for (int i = 0; i < 12; i++) begin
      set_px(bh[i], bv[i], bs[i]);
      expect_at(2, brgb[i], 1'b0, 0, $sformatf("bound%0d", i));
      tick(2);
    end

    // First press from WAIT_PRESS
    set_px(200, 150, 0);
    bus.start_key = 1'b1;
`ifdef START_FADE_EN
    expect_at(2, 12'hF00, 1'b0, 0, "press_pre");
    expect_at(4, 12'hF00, 1'b0, 0, "fade_lvl0");
    tick(5);
    set_px(200, 150, 1); expect_at(2, 12'h070, 1'b0, 0, "fade_lvl1");    tick(3);
    set_px(100, 150, 1); expect_at(2, 12'h000, 1'b0, 0, "fade_lvl1_bg"); tick(2);
    set_px(200, 150, 2); expect_at(2, 12'h003, 1'b0, 0, "fade_lvl2");    tick(3);
    set_px(200, 150, 3); expect_at(2, 12'h110, 1'b0, 0, "fade_lvl3");    tick(3);
    set_px(200, 150, 0);
    expect_at(1, 12'h110, 1'b1, 1, "fade_game_start");
    expect_at(2, 12'h000, 1'b1, 1, "done_black");
    tick(3);
`else
    expect_at(2, 12'hF00, 1'b0, 0, "press_pre");
    expect_at(3, 12'hF00, 1'b1, 1, "press_game_start");
    expect_at(4, 12'h000, 1'b1, 1, "done_black");
    tick(5);
`endif

    // Further presses ignored in DONE
    bus.start_key = 1'b0; tick(3);
    bus.start_key = 1'b1; tick(6);
    expect_at(1, 12'h000, 1'b1, 1, "press_ignored");
    tick(2);

    // Asynchronous reset with the key held through release
    @(posedge clk); #2;
    rst = 1'b1; #1;
    expect_at(0, 12'h000, 1'b0, 1, "rst_async");
    tick(3);
    rst = 1'b0;
    set_px(200, 150, 0);
    tick(10);
    expect_at(2, 12'hF00, 1'b0, 1, "held_no_start"); tick(2);
    set_px(200, 150, 1);
    expect_at(2, 12'h0F0, 1'b0, 1, "held_no_fade");  tick(2);
    bus.start_key = 1'b0;
    tick(4);

    set_px(200, 150, 0);
    bus.start_key = 1'b1;
`ifdef START_FADE_EN
    // Press edge coinciding with a scene change enters FADE at level 0
    tick(2);
    set_px(200, 150, 1);
    expect_at(2, 12'h0F0, 1'b0, 1, "coincide_lvl0"); tick(3);
    set_px(200, 150, 2); expect_at(2, 12'h007, 1'b0, 1, "coincide_lvl1"); tick(3);
    set_px(200, 150, 3); expect_at(2, 12'h330, 1'b0, 1, "coincide_lvl2"); tick(3);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    expect_at(0, 12'h000, 1'b0, 1, "rst_mid_fade");
    tick(1);
    bus.start_key = 1'b0;
    tick(1);
    rst = 1'b0;
    set_px(200, 150, 0);
    expect_at(1, 12'h000, 1'b0, 1, "flush_after_rst");
    expect_at(2, 12'hF00, 1'b0, 1, "post_rst_title");
    tick(3);
    set_px(200, 150, 1); expect_at(2, 12'h0F0, 1'b0, 1, "post_rst_nofade"); tick(4);
    bus.start_key = 1'b1; tick(5);
    expect_at(2, 12'h0F0, 1'b0, 1, "repress_lvl0"); tick(3);
    set_px(200, 150, 2); expect_at(2, 12'h007, 1'b0, 1, "repress_lvl1"); tick(3);
`else
    expect_at(3, 12'hF00, 1'b1, 2, "repress_game_start");
    expect_at(4, 12'h000, 1'b1, 2, "repress_done");
    tick(6);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    expect_at(0, 12'h000, 1'b0, 2, "rst_in_done");
    tick(1);
    bus.start_key = 1'b0;
    tick(1);
    rst = 1'b0;
    set_px(200, 150, 0);
    expect_at(1, 12'h000, 1'b0, 2, "flush_after_rst");
    expect_at(2, 12'hF00, 1'b0, 2, "post_rst_title");
    tick(3);
`endif

    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
